// File: rtl/fifo_umbral_pkg.sv
// Flow-control constants shared by the transmission-layer state machine and
// every FIFO instance (main, VC0/VC1, D0/D1).
package fifo_umbral_pkg;

    localparam int FC_DATA_WIDTH = 10;
    localparam int FC_ADDR_WIDTH = 3;
    localparam int FC_DEPTH      = 2 ** FC_ADDR_WIDTH;
    localparam int FC_UMBRAL_W   = 4;

    // Operation accepted on one edge, encoded as {write, read}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/memoria_fifo.sv
// Simple dual-port RAM: synchronous write port, synchronous read port with
// read enable. The read register holds its value when no read is issued.
module memoria_fifo
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ADDR_WIDTH = FC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array: written on the rising edge, never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register: a same-address write in the same cycle returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty threshold and
// a sticky overflow/underflow error flag. Status outputs feed the
// flow-control state machine; the threshold comes back from it.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ADDR_WIDTH = FC_ADDR_WIDTH,
    parameter int UMBRAL_W   = FC_UMBRAL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [UMBRAL_W-1:0]   umbral,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  error
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int MW = (UMBRAL_W > CW) ? UMBRAL_W : CW;
    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);
    localparam logic [MW-1:0] DEPTH_M = MW'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         umbral_q, umbral_d;
    logic                  error_q, error_d;
    logic                  valid_q, valid_d;

    logic                  empty_s, full_s;
    logic                  rd_acc_s, wr_acc_s;
    logic [MW-1:0]         umbral_ext_s;
    fifo_op_e              op_s;

    assign empty_s = (count_q == {CW{1'b0}});
    assign full_s  = (count_q == DEPTH_C);

    // Accept logic and next-state for pointers, occupancy, threshold and error.
    always_comb begin
        rd_acc_s     = rd_enable && !empty_s;
        wr_acc_s     = wr_enable && (!full_s || rd_acc_s);
        op_s         = fifo_op_e'({wr_acc_s, rd_acc_s});
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        valid_d      = rd_acc_s;
        umbral_ext_s = MW'(umbral);

        case (op_s)
            OP_WRITE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            OP_READ: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: begin
                count_d = count_q;
            end
        endcase

        // Dropped write (overflow) or rejected read (underflow) latches the error.
        error_d = error_q | (wr_enable && !wr_acc_s) | (rd_enable && empty_s);

        if (!init) begin
            umbral_d = umbral_q;
        end else if (umbral_ext_s > DEPTH_M) begin
            umbral_d = DEPTH_C;
        end else begin
            umbral_d = CW'(umbral);
        end
    end

    // Control state registers; memory contents survive reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            umbral_q <= '0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            umbral_q <= umbral_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
        end
    end

    memoria_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_memoria_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (wr_acc_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_acc_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

    assign valid_out    = valid_q;
    assign count        = count_q;
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_q <= umbral_q);
    assign almost_full  = (count_q >= (DEPTH_C - umbral_q));
    assign error        = error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: directed walk through the main
// scenarios followed by randomized traffic, against a queue-based model.
module tb_fifo_umbral;

    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int UW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          init = 1'b0;
    logic [UW-1:0] umbral = '0;
    logic          wr_enable = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_enable = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          empty, full, almost_empty, almost_full, error;

    fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UMBRAL_W(UW)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral       (umbral),
        .wr_enable    (wr_enable),
        .data_in      (data_in),
        .rd_enable    (rd_enable),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_q[$];
    int          m_umb;
    bit          m_err;
    int          m_dout;
    bit          m_vld;

    int n_checks   = 0;
    int n_failures = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check_val("data_out",     int'(data_out),     m_dout);
        check_val("valid_out",    int'(valid_out),    int'(m_vld));
        check_val("count",        int'(count),        n);
        check_val("empty",        int'(empty),        int'(n == 0));
        check_val("full",         int'(full),         int'(n == DEPTH));
        check_val("almost_empty", int'(almost_empty), int'(n <= m_umb));
        check_val("almost_full",  int'(almost_full),  int'(n >= DEPTH - m_umb));
        check_val("error",        int'(error),        int'(m_err));
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_umb  = 0;
        m_err  = 1'b0;
        m_dout = 0;
        m_vld  = 1'b0;
    endfunction

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic step(input bit i, input int u, input bit w, input int d, input bit r);
        bit rd_ok, wr_ok, was_empty, was_full;
        init      = i;
        umbral    = UW'(u);
        wr_enable = w;
        data_in   = DW'(d);
        rd_enable = r;
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        rd_ok = r && !was_empty;
        wr_ok = w && (!was_full || rd_ok);
        if ((w && !wr_ok) || (r && was_empty)) m_err = 1'b1;
        if (rd_ok) begin
            m_dout = m_q.pop_front();
            m_vld  = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        if (wr_ok) m_q.push_back(d & 32'h3FF);
        if (i) m_umb = (u > DEPTH) ? DEPTH : u;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        init = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all();
        @(posedge clk); #1;
        reset = 1'b1;
        check_all();

        // Threshold 2, then six writes
        step(1'b1, 2, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 6; k++) step(1'b0, 0, 1'b1, k, 1'b0);
        check_val("tp1_almost_full", int'(almost_full), 1);
        // Fill and overflow
        step(1'b0, 0, 1'b1, 7, 1'b0);
        step(1'b0, 0, 1'b1, 8, 1'b0);
        step(1'b0, 0, 1'b1, 'h3FF, 1'b0);
        check_val("tp2_error", int'(error), 1);
        // Simultaneous write/read at full, then drain across the wrap
        step(1'b0, 0, 1'b1, 'h055, 1'b1);
        check_val("tp3_first", int'(data_out), 'h001);
        for (int k = 0; k < 8; k++) step(1'b0, 0, 1'b0, 0, 1'b1);
        check_val("tp3_last", int'(data_out), 'h055);
        // Underflow with concurrent write, then read back
        step(1'b0, 0, 1'b1, 'h0AA, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        check_val("tp4_read", int'(data_out), 'h0AA);
        // Clamped threshold, then asynchronous reset mid-stream
        step(1'b1, 'hF, 1'b1, 'h111, 1'b0);
        step(1'b0, 0, 1'b1, 'h222, 1'b1);
        step(1'b0, 0, 1'b1, 'h333, 1'b0);
        pulse_reset();
        step(1'b0, 0, 1'b1, 'h044, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // Randomized traffic with varying write/read bias
        begin
            int wbias, rbias;
            wbias = 50; rbias = 50;
            for (int c = 0; c < 2000; c++) begin
                if ((c % 64) == 0) begin
                    wbias = $urandom_range(10, 90);
                    rbias = $urandom_range(10, 90);
                end
                if ($urandom_range(0, 299) == 0) begin
                    pulse_reset();
                end
                step($urandom_range(0, 15) == 0, $urandom_range(0, 15),
                     $urandom_range(0, 99) < wbias, $urandom_range(0, 1023),
                     $urandom_range(0, 99) < rbias);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
